// File: rtl/gshare_bp_pkg.sv
// Shared constants for the gshare branch predictor: default geometry,
// boolean aliases and the reset value of a saturating counter.
package gshare_bp_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int BP_TAG_WIDTH  = 8;
    localparam int BP_CNT_WIDTH  = 2;
    localparam int BP_GHR_WIDTH  = 6;
    localparam int BP_TABLE_SIZE = 1 << BP_TAG_WIDTH;

    // Weakly not-taken: the largest value whose MSB is still 0.
    function automatic int bp_cnt_init(input int w);
        return (1 << (w - 1)) - 1;
    endfunction
endpackage

// File: rtl/bp_sat_cnt.sv
// Combinational saturating up/down counter step used on the commit path.
module bp_sat_cnt
    import gshare_bp_pkg::*;
#(
    parameter int CNT_WIDTH = BP_CNT_WIDTH
) (
    input  logic [CNT_WIDTH-1:0] cur,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] nxt
);
    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != {CNT_WIDTH{1'b1}}) nxt = cur + 1'b1;
        end else begin
            if (cur != {CNT_WIDTH{1'b0}}) nxt = cur - 1'b1;
        end
    end
endmodule

// File: rtl/gshare_bp.sv
// gshare predictor: counter table indexed by tag ^ GHR, speculative GHR with
// mispredict repair. Define BP_STATS_EN to add commit/mispredict counters.
module gshare_bp
    import gshare_bp_pkg::*;
#(
    parameter int TAG_WIDTH = BP_TAG_WIDTH,
    parameter int CNT_WIDTH = BP_CNT_WIDTH,
    parameter int GHR_WIDTH = BP_GHR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_fetcher_ce,
    input  logic [TAG_WIDTH-1:0] in_fetcher_tag,
    output logic                 out_fetcher_jump_ce,
    output logic [GHR_WIDTH-1:0] out_fetcher_ghr,
    input  logic                 in_rob_bp_ce,
    input  logic [TAG_WIDTH-1:0] in_rob_tag,
    input  logic [GHR_WIDTH-1:0] in_rob_ghr,
    input  logic                 in_rob_jump_ce,
    input  logic                 in_rob_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]          out_stat_commit_cnt,
    output logic [31:0]          out_stat_mispredict_cnt
`endif
);
    localparam int DEPTH = 1 << TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(bp_cnt_init(CNT_WIDTH));

    logic [CNT_WIDTH-1:0] table_q [DEPTH];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [GHR_WIDTH-1:0] ghr_spec, ghr_fix;
    logic [TAG_WIDTH-1:0] rd_idx, wr_idx;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    assign rd_idx = in_fetcher_tag ^ TAG_WIDTH'(ghr_q);
    assign wr_idx = in_rob_tag ^ TAG_WIDTH'(in_rob_ghr);

    // Read is pre-update: a same-cycle commit to rd_idx is not bypassed.
    assign out_fetcher_jump_ce = table_q[rd_idx][CNT_WIDTH-1];
    assign out_fetcher_ghr     = ghr_q;

    bp_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sat (
        .cur (table_q[wr_idx]),
        .inc (in_rob_jump_ce),
        .nxt (cnt_nxt)
    );

    generate
        if (GHR_WIDTH == 1) begin : g_ghr1
            assign ghr_spec = out_fetcher_jump_ce;
            assign ghr_fix  = in_rob_jump_ce;
        end else begin : g_ghrn
            assign ghr_spec = {ghr_q[GHR_WIDTH-2:0], out_fetcher_jump_ce};
            assign ghr_fix  = {in_rob_ghr[GHR_WIDTH-2:0], in_rob_jump_ce};
        end
    endgenerate

    // Repair wins over a same-cycle fetch, which is on the wrong path.
    always_comb begin
        ghr_d = ghr_q;
        if (in_rob_bp_ce && in_rob_mispredict) ghr_d = ghr_fix;
        else if (in_fetcher_ce)                ghr_d = ghr_spec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= CNT_INIT;
            ghr_q <= '0;
        end else if (rdy) begin
            ghr_q <= ghr_d;
            if (in_rob_bp_ce) table_q[wr_idx] <= cnt_nxt;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] commit_cnt_q, mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (rdy && in_rob_bp_ce) begin
            if (commit_cnt_q != 32'hFFFF_FFFF) commit_cnt_q <= commit_cnt_q + 32'd1;
            if (in_rob_mispredict && mispredict_cnt_q != 32'hFFFF_FFFF)
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign out_stat_commit_cnt     = commit_cnt_q;
    assign out_stat_mispredict_cnt = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_gshare_bp.sv
// Directed-vector bench for gshare_bp (default 8-bit tag, 2-bit counters, 6-bit GHR).
module tb_gshare_bp;
    logic       clk = 1'b0;
    logic       rst, rdy;
    logic       in_fetcher_ce;
    logic [7:0] in_fetcher_tag;
    logic       out_fetcher_jump_ce;
    logic [5:0] out_fetcher_ghr;
    logic       in_rob_bp_ce;
    logic [7:0] in_rob_tag;
    logic [5:0] in_rob_ghr;
    logic       in_rob_jump_ce;
    logic       in_rob_mispredict;
`ifdef BP_STATS_EN
    logic [31:0] out_stat_commit_cnt, out_stat_mispredict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_bp dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .in_fetcher_ce       (in_fetcher_ce),
        .in_fetcher_tag      (in_fetcher_tag),
        .out_fetcher_jump_ce (out_fetcher_jump_ce),
        .out_fetcher_ghr     (out_fetcher_ghr),
        .in_rob_bp_ce        (in_rob_bp_ce),
        .in_rob_tag          (in_rob_tag),
        .in_rob_ghr          (in_rob_ghr),
        .in_rob_jump_ce      (in_rob_jump_ce),
        .in_rob_mispredict   (in_rob_mispredict)
`ifdef BP_STATS_EN
        ,
        .out_stat_commit_cnt     (out_stat_commit_cnt),
        .out_stat_mispredict_cnt (out_stat_mispredict_cnt)
`endif
    );

    // Inputs held for one cycle; expectations are the outputs seen during that cycle.
    typedef struct {
        logic       rst, rdy, fce;
        logic [7:0] ftag;
        logic       bce;
        logic [7:0] btag;
        logic [5:0] bghr;
        logic       bj, bm;
        logic       ej;
        logic [5:0] eg;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic r, logic y, logic fce, logic [7:0] ftag,
                                logic bce, logic [7:0] btag, logic [5:0] bghr,
                                logic bj, logic bm, logic ej, logic [5:0] eg);
        vec_t v;
        v.rst = r; v.rdy = y; v.fce = fce; v.ftag = ftag;
        v.bce = bce; v.btag = btag; v.bghr = bghr; v.bj = bj; v.bm = bm;
        v.ej = ej; v.eg = eg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; rdy = v.rdy;
        in_fetcher_ce = v.fce; in_fetcher_tag = v.ftag;
        in_rob_bp_ce = v.bce; in_rob_tag = v.btag; in_rob_ghr = v.bghr;
        in_rob_jump_ce = v.bj; in_rob_mispredict = v.bm;
    endtask

    task automatic idle_inputs();
        drive(mk(1, 1, 0, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0, 6'h00));
    endtask

    task automatic sweep(input string tagname);
        for (int t = 0; t < 256; t++) begin
            @(negedge clk);
            in_fetcher_tag = 8'(t);
            #1;
            check($sformatf("%s_jump_tag%02h", tagname, t), 32'(out_fetcher_jump_ce), 32'd0);
        end
        check({tagname, "_ghr"}, 32'(out_fetcher_ghr), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        sweep("reset");

        //            rst rdy fce ftag   bce btag   bghr   bj bm  ej eg
        // counter at index 0x12: 01 ->10->11->11 ->10->01->00->00 ->01->10
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 1, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 1, 0, 1, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 1, 0, 1, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 0, 0, 1, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 0, 0, 1, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 0, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 0, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 1, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 0, 8'h00, 6'h00, 0, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 1, 8'h12, 6'h00, 1, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h12, 0, 8'h00, 6'h00, 0, 0, 1, 6'h00));
        // speculative shifts of predictions 0,1,1
        vecs.push_back(mk(1, 1, 1, 8'h20, 0, 8'h00, 6'h00, 0, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 1, 8'h12, 0, 8'h00, 6'h00, 0, 0, 1, 6'h00));
        vecs.push_back(mk(1, 1, 1, 8'h13, 0, 8'h00, 6'h00, 0, 0, 1, 6'h01));
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0, 6'h03));
        // mispredict repair loads ghr = 101010
        vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h15, 6'h15, 0, 1, 0, 6'h03));
        // repair vs same-cycle fetch (fetch would shift in a 1)
        vecs.push_back(mk(1, 1, 1, 8'h38, 1, 8'h40, 6'h07, 0, 1, 1, 6'h2A));
        // mispredict without commit is ignored
        vecs.push_back(mk(1, 1, 0, 8'h49, 0, 8'h00, 6'h00, 1, 1, 0, 6'h0E));
        vecs.push_back(mk(1, 1, 0, 8'h1C, 0, 8'h00, 6'h00, 0, 0, 1, 6'h0E));
        // rdy low: strobes must not change table or ghr
        vecs.push_back(mk(1, 0, 1, 8'h1C, 1, 8'h1C, 6'h0E, 0, 1, 1, 6'h0E));
        vecs.push_back(mk(1, 0, 1, 8'h1C, 1, 8'h1C, 6'h0E, 0, 1, 1, 6'h0E));
        vecs.push_back(mk(1, 0, 1, 8'h1C, 1, 8'h1C, 6'h0E, 0, 1, 1, 6'h0E));
        vecs.push_back(mk(1, 1, 0, 8'h1C, 0, 8'h00, 6'h00, 0, 0, 1, 6'h0E));
        // reset in the middle of a commit stream
        vecs.push_back(mk(1, 1, 0, 8'h1C, 1, 8'h12, 6'h00, 1, 0, 1, 6'h0E));
        vecs.push_back(mk(0, 1, 1, 8'h1C, 1, 8'h55, 6'h00, 1, 0, 1, 6'h0E));
        vecs.push_back(mk(1, 1, 0, 8'h12, 0, 8'h00, 6'h00, 0, 0, 0, 6'h00));
        vecs.push_back(mk(1, 1, 0, 8'h55, 0, 8'h00, 6'h00, 0, 0, 0, 6'h00));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_jump", i), 32'(out_fetcher_jump_ce), 32'(vecs[i].ej));
            check($sformatf("v%0d_ghr", i), 32'(out_fetcher_ghr), 32'(vecs[i].eg));
        end

        @(negedge clk);
        idle_inputs();
        sweep("post_reset");

`ifdef BP_STATS_EN
        begin
            logic [9:0] mis_pat;
            mis_pat = 10'b0010010010;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("stat_commit_reset", out_stat_commit_cnt, 32'd0);
            check("stat_mis_reset", out_stat_mispredict_cnt, 32'd0);
            rst = 1'b1;
            for (int k = 0; k < 10; k++) begin
                in_rob_bp_ce = 1'b1;
                in_rob_tag = 8'(k);
                in_rob_mispredict = mis_pat[k];
                @(negedge clk);
            end
            // idle and rdy-low commits must not count
            in_rob_bp_ce = 1'b0; in_rob_mispredict = 1'b1;
            @(negedge clk);
            rdy = 1'b0; in_rob_bp_ce = 1'b1;
            @(negedge clk);
            rdy = 1'b1; in_rob_bp_ce = 1'b0; in_rob_mispredict = 1'b0;
            #1;
            check("stat_commit_cnt", out_stat_commit_cnt, 32'd10);
            check("stat_mis_cnt", out_stat_mispredict_cnt, 32'd3);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gshare_bp.md
Name: gshare_bp

Overview:
- Parametrised successor to the per-tag 2-bit branch predictor.
- Global-history (gshare) predictor: table index = fetcher tag XOR global history register (GHR).
- Saturating counter width is a parameter. GHR is updated speculatively at fetch and repaired on mispredict from ROB commit.
- Sits between fetcher (prediction query) and ROB (commit feedback).

Parameters:
- TAG_WIDTH, 8, index bits; table depth = 2**TAG_WIDTH.
- CNT_WIDTH, 2, saturating counter width; legal range 1..4.
- GHR_WIDTH, 6, global history bits; must satisfy 1 <= GHR_WIDTH <= TAG_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- rdy  in  1  global ready; when 0, no state changes
- in_fetcher_ce  in  1  fetcher issues a conditional branch this cycle
- in_fetcher_tag  in  TAG_WIDTH  branch PC tag
- out_fetcher_jump_ce  out  1  predicted taken (combinational)
- out_fetcher_ghr  out  GHR_WIDTH  current GHR snapshot; fetcher carries it with the instruction to the ROB
- in_rob_bp_ce  in  1  ROB commits a conditional branch
- in_rob_tag  in  TAG_WIDTH  tag of committed branch
- in_rob_ghr  in  GHR_WIDTH  GHR snapshot carried with that branch
- in_rob_jump_ce  in  1  actual outcome, 1 = taken
- in_rob_mispredict  in  1  committed prediction was wrong; pipeline is flushing

Behaviour:
- Lookup (combinational):
  - Index = in_fetcher_tag XOR zero-extend(ghr).
  - out_fetcher_jump_ce = MSB of table[index]. out_fetcher_ghr = ghr.
  - Both outputs are valid every cycle, regardless of in_fetcher_ce and rdy.
- Reset (rst==0 at posedge clk):
  - Every entry is set to 2**(CNT_WIDTH-1)-1 (weakly not-taken; 2'b01 for CNT_WIDTH=2).
  - ghr = 0.
  - Outputs after reset: out_fetcher_jump_ce = 0, out_fetcher_ghr = 0.
  - Reset overrides any in-flight update.
- rdy==0: table and ghr hold; all inputs are ignored.
- Commit update (rst==1, rdy==1, in_rob_bp_ce==1):
  - Update index = in_rob_tag XOR zero-extend(in_rob_ghr).
  - Taken: entry += 1, saturating at 2**CNT_WIDTH-1.
  - Not taken: entry -= 1, saturating at 0.
  - Written at the clock edge; visible to lookup the next cycle.
- Same-cycle read/write: if the lookup index equals the update index, the lookup returns the pre-update value (no bypass).
- GHR next-state (rst==1, rdy==1), priority order:
  1. in_rob_bp_ce && in_rob_mispredict: ghr <= {in_rob_ghr[GHR_WIDTH-2:0], in_rob_jump_ce}. Any same-cycle in_fetcher_ce is discarded (fetch is wrong-path).
  2. in_fetcher_ce: ghr <= {ghr[GHR_WIDTH-2:0], out_fetcher_jump_ce}, i.e. a speculative shift of the prediction.
  3. Otherwise ghr holds.
  - For GHR_WIDTH==1 the shift degenerates to ghr <= new bit.
- in_rob_mispredict is ignored when in_rob_bp_ce==0.
- Back-to-back fetches shift the GHR every cycle. Commits may arrive every cycle.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds two outputs, out_stat_commit_cnt [31:0] and out_stat_mispredict_cnt [31:0].
  - They count, respectively, cycles with in_rob_bp_ce and cycles with in_rob_bp_ce&&in_rob_mispredict, while rdy==1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- constant.v holds:
  - TRUE/FALSE.
  - Default BP_TAG_WIDTH, BP_CNT_WIDTH, BP_GHR_WIDTH.
  - Derived table size.
- Sub-module bp_sat_cnt (combinational): inputs cur[CNT_WIDTH], inc. Output next value, saturating. One instance, used by the commit path.

Test Plan:
- Reset then lookup with tag 0x00..0xFF and ghr=0: jump_ce=0 for every entry; out_fetcher_ghr=0.
- Commit tag 0x12, ghr 0, taken ×3: entry 01->10->11->11 (saturates); lookup at index 0x12 gives jump_ce=1 from the cycle after the 1st commit. Then not-taken ×4: 11->10->01->00->00.
- Fetch ce with predictions 0,1,1 on consecutive cycles (GHR_WIDTH=6): ghr 000000->000000->000001->000011.
- Mispredict: ghr=6'b101010, and in the same cycle in_fetcher_ce=1 plus commit with in_rob_ghr=6'b000111, jump=0, mispredict=1: ghr becomes 6'b001110; the fetch shift is dropped.
- rdy=0 for 3 cycles with commit and fetch strobes asserted: table and ghr unchanged. rst=0 for one edge in the middle of a commit stream: all entries back to 01 and ghr=0.
- BP_STATS_EN: 10 commits with 3 mispredicts -> out_stat_commit_cnt=10, out_stat_mispredict_cnt=3.
